// File: rtl/cdb_result_queue.sv
// Result holding FIFO between one functional unit and the CDB arbiter.
// Optional feature: define RESULT_BYPASS_EN for same-cycle bypass on an idle queue.
module cdb_result_queue #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     flush,
  input  logic                     fuValid,
  input  logic [WIDTH:0]           fuResult,
  input  logic [ROB:0]             fuRob,
  output logic                     fuReady,
  output logic                     cdbRequest,
  output logic [WIDTH:0]           cdbResult,
  output logic [ROB:0]             cdbRob,
  input  logic                     cdbGrant,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = WIDTH + ROB + 2;
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [EW-1:0]   mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW:0]     count_r;
  logic [EW-1:0]   head_s;
  logic            bypass_s;
  logic            enq_s;
  logic            deq_s;
  logic            held_s;

  assign held_s  = (count_r != {(PW + 1){1'b0}});
  assign fuReady = (count_r != FULL_COUNT);
  assign count   = count_r;
  assign head_s  = mem_r[rd_ptr_r];

`ifdef RESULT_BYPASS_EN
  assign bypass_s = fuValid && !held_s && !flush && !clear;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed result that is granted immediately never touches storage.
  assign enq_s = fuValid && fuReady && !flush && !clear && !(bypass_s && cdbGrant);
  assign deq_s = cdbGrant && held_s && !flush && !clear;

  // Arbiter-facing head view: stored head, bypassed FU result, or zeros.
  always_comb begin
    cdbRequest = 1'b0;
    cdbResult  = {(WIDTH + 1){1'b0}};
    cdbRob     = {(ROB + 1){1'b0}};
    if (held_s) begin
      cdbRequest = 1'b1;
      cdbResult  = head_s[EW-1:ROB+1];
      cdbRob     = head_s[ROB:0];
    end else if (bypass_s) begin
      cdbRequest = 1'b1;
      cdbResult  = fuResult;
      cdbRob     = fuRob;
    end else begin
      cdbRequest = 1'b0;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[wr_ptr_r] <= {fuResult, fuRob};
    end
  end

  // Pointer and occupancy update; clear and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (clear || flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Self-checking bench for cdb_result_queue: directed vector table, wrap sequence,
// and randomized traffic against a queue-based reference model.
module tb_cdb_result_queue;

  localparam int WIDTH = 31;
  localparam int ROB   = 2;
  localparam int DEPTH = 4;
`ifdef RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              clear;
  logic              flush;
  logic              fuValid;
  logic [WIDTH:0]    fuResult;
  logic [ROB:0]      fuRob;
  logic              fuReady;
  logic              cdbRequest;
  logic [WIDTH:0]    cdbResult;
  logic [ROB:0]      cdbRob;
  logic              cdbGrant;
  logic [2:0]        count;

  int n_cmp;
  int n_fail;

  cdb_result_queue #(.WIDTH(WIDTH), .ROB(ROB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clear      (clear),
    .flush      (flush),
    .fuValid    (fuValid),
    .fuResult   (fuResult),
    .fuRob      (fuRob),
    .fuReady    (fuReady),
    .cdbRequest (cdbRequest),
    .cdbResult  (cdbResult),
    .cdbRob     (cdbRob),
    .cdbGrant   (cdbGrant),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          clr;
    bit          fl;
    bit          v;
    logic [31:0] res;
    logic [2:0]  rob;
    bit          g;
    bit          e_req;
    logic [31:0] e_res;
    logic [2:0]  e_rob;
    logic [2:0]  e_cnt;
    bit          e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit clr, bit fl, bit v, int res, int rob, bit g,
                              bit e_req, int e_res, int e_rob, int e_cnt, bit e_rdy);
    vec_t t;
    t.clr = clr; t.fl = fl; t.v = v; t.res = res; t.rob = rob[2:0]; t.g = g;
    t.e_req = e_req; t.e_res = e_res; t.e_rob = e_rob[2:0]; t.e_cnt = e_cnt[2:0];
    t.e_rdy = e_rdy;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit clr, bit fl, bit v, logic [31:0] res, logic [2:0] rob, bit g);
    clear = clr; flush = fl; fuValid = v; fuResult = res; fuRob = rob; cdbGrant = g;
  endtask

  task automatic check_all(string tag, bit e_req, logic [31:0] e_res, logic [2:0] e_rob,
                           logic [2:0] e_cnt, bit e_rdy);
    check({tag, ".req"},   64'(cdbRequest), 64'(e_req));
    check({tag, ".res"},   64'(cdbResult),  64'(e_res));
    check({tag, ".rob"},   64'(cdbRob),     64'(e_rob));
    check({tag, ".count"}, 64'(count),      64'(e_cnt));
    check({tag, ".ready"}, 64'(fuReady),    64'(e_rdy));
  endtask

  // Reference model: a plain FIFO of {result, rob} words.
  logic [34:0] mq[$];

  initial begin
    bit          r_clr, r_fl, r_v, r_g, byp, deq, enq;
    logic [31:0] r_res, e_res;
    logic [2:0]  r_rob, e_rob;
    bit          e_req;

    clk = 1'b0; n_cmp = 0; n_fail = 0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 1'b0);
    @(posedge clk); #1;

    // Clear with a valid result present: nothing may be captured.
    drive(1'b1, 1'b0, 1'b1, 32'd77, 3'd6, 1'b1);
    @(posedge clk); #1;

    //            clr fl v  res rob g   req  res        rob       cnt rdy
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0,   0,          0,        0, 1));
    vecs.push_back(mk(0, 0, 1, 60, 1, 0,  BYP, BYP ? 60:0, BYP ? 1:0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  1,   60,         1,        1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1,  1,   60,         1,        1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0,   0,          0,        0, 1));
    vecs.push_back(mk(0, 0, 1, 10, 0, 0,  BYP, BYP ? 10:0, 0,        0, 1));
    vecs.push_back(mk(0, 0, 1, 11, 1, 0,  1,   10,         0,        1, 1));
    vecs.push_back(mk(0, 0, 1, 12, 2, 0,  1,   10,         0,        2, 1));
    vecs.push_back(mk(0, 0, 1, 13, 3, 0,  1,   10,         0,        3, 1));
    vecs.push_back(mk(0, 0, 1, 14, 4, 0,  1,   10,         0,        4, 0));
    vecs.push_back(mk(0, 0, 1, 15, 5, 1,  1,   10,         0,        4, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1,  1,   11,         1,        3, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1,  1,   12,         2,        2, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1,  1,   13,         3,        1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0,   0,          0,        0, 1));
    vecs.push_back(mk(0, 0, 1, 99, 5, 1,  BYP, BYP ? 99:0, BYP ? 5:0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  !BYP, BYP ? 0:99, BYP ? 0:5, BYP ? 0:1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1,  !BYP, BYP ? 0:99, BYP ? 0:5, BYP ? 0:1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0,   0,          0,        0, 1));
    vecs.push_back(mk(0, 0, 1, 21, 1, 0,  BYP, BYP ? 21:0, BYP ? 1:0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 22, 2, 0,  1,   21,         1,        1, 1));
    vecs.push_back(mk(0, 0, 1, 23, 3, 0,  1,   21,         1,        2, 1));
    vecs.push_back(mk(0, 1, 1, 30, 6, 1,  1,   21,         1,        3, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0,   0,          0,        0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0,   0,          0,        0, 1));
    vecs.push_back(mk(0, 0, 1, 40, 7, 0,  BYP, BYP ? 40:0, BYP ? 7:0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 41, 2, 1,  1,   40,         7,        1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0,   0,          0,        0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].fl, vecs[i].v, vecs[i].res, vecs[i].rob, vecs[i].g);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_res, vecs[i].e_rob,
                vecs[i].e_cnt, vecs[i].e_rdy);
      @(posedge clk); #1;
    end

    // Wrap-around: prime two entries, then enqueue and grant together each cycle.
    drive(1'b0, 1'b0, 1'b1, 32'd100, 3'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'd101, 3'd1, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'(102 + k), 3'((2 + k) % 8), 1'b1);
      #1;
      check_all($sformatf("wrap%0d", k), 1'b1, 32'(100 + k), 3'(k % 8), 3'd2, 1'b1);
      @(posedge clk); #1;
    end
    for (int k = 10; k < 12; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 1'b1);
      #1;
      check_all($sformatf("drain%0d", k), 1'b1, 32'(100 + k), 3'(k % 8), 3'(12 - k), 1'b1);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 1'b0);
    #1;
    check_all("drained", 1'b0, 32'd0, 3'd0, 3'd0, 1'b1);
    @(posedge clk); #1;

    // Randomized traffic against the FIFO model (starts empty).
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      r_clr = ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 39) == 0);
      r_v   = ($urandom_range(0, 9) < 6);
      r_g   = ($urandom_range(0, 9) < 5);
      r_res = $urandom;
      r_rob = 3'($urandom_range(0, 7));
      drive(r_clr, r_fl, r_v, r_res, r_rob, r_g);
      #1;
      byp = BYP && r_v && (mq.size() == 0) && !r_fl && !r_clr;
      if (mq.size() > 0) begin
        e_req = 1'b1; e_res = mq[0][34:3]; e_rob = mq[0][2:0];
      end else if (byp) begin
        e_req = 1'b1; e_res = r_res; e_rob = r_rob;
      end else begin
        e_req = 1'b0; e_res = 32'd0; e_rob = 3'd0;
      end
      check_all($sformatf("rnd%0d", c), e_req, e_res, e_rob, 3'(mq.size()),
                mq.size() != DEPTH);
      @(posedge clk); #1;
      if (r_clr || r_fl) begin
        mq.delete();
      end else begin
        deq = r_g && (mq.size() > 0);
        enq = r_v && (mq.size() < DEPTH) && !(byp && r_g);
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back({r_res, r_rob});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
